// File: rtl/intf_rr_arbiter.sv
// Round-robin burst arbiter: NREQ requesters share one registered data channel.
// A grant lasts until the owner signals last, drops its request, or reaches
// MAX_BEATS beats. Grants are separated by at least one idle cycle.
// Optional statistics outputs (grant_total, forced_rel) exist only when
// INTF_RR_ARBITER_STATS_EN is defined.
module intf_rr_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               out_owner,
  output logic                     busy
`ifdef INTF_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]              grant_total,
  output logic                     forced_rel
`endif
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [2:0]          rr_q, rr_d;
  logic [2:0]          owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          out_owner_q, out_owner_d;

  logic [2:0]          sel, sel_hi, sel_lo;
  logic                found_hi;
  logic                own_req, own_last;
  logic [DATA_W-1:0]   own_data;
  logic                beat, hit_limit, release_now;

  // Pick the first requester at or above the rr pointer, else wrap to the lowest one.
  always_comb begin
    sel_hi   = 3'd0;
    sel_lo   = 3'd0;
    found_hi = 1'b0;
    // Descending scan so the last hit recorded is the lowest index.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = 3'(i);
        if (3'(i) >= rr_q) begin
          sel_hi   = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // Route the current owner's request, last flag and data slice.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_owner_d = out_owner_q;
    beat        = 1'b0;
    hit_limit   = 1'b0;
    release_now = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          owner_d = sel;
          cnt_d   = 8'd0;
          for (int i = 0; i < NREQ; i++) begin
            gnt_d[i] = (sel == 3'(i));
          end
        end
      end

      StGrant: begin
        beat      = own_req;
        hit_limit = beat && (({1'b0, cnt_q} + 9'd1) == 9'(MAX_BEATS));
        if (beat) begin
          out_valid_d = 1'b1;
          out_data_d  = own_data;
          out_owner_d = owner_q;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        // Abandon (no request), last beat, or beat limit: all one release.
        release_now = !own_req || own_last || hit_limit;
        if (release_now) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= 3'd0;
      owner_q     <= 3'd0;
      cnt_q       <= 8'd0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_owner_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_owner_q <= out_owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_owner = out_owner_q;
  assign busy      = (state_q == StGrant);

`ifdef INTF_RR_ARBITER_STATS_EN
  logic [15:0] grant_total_q;
  logic        forced_rel_q;

  // Count grants as they are issued; flag releases caused only by the beat limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_total_q <= 16'd0;
      forced_rel_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && (|req)) begin
        grant_total_q <= grant_total_q + 16'd1;
      end
      forced_rel_q <= (state_q == StGrant) && hit_limit && !own_last;
    end
  end

  assign grant_total = grant_total_q;
  assign forced_rel  = forced_rel_q;
`endif

  // Grant stays at most one-hot and is present exactly while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (busy == (gnt_q != '0));
    end
  end

endmodule
